// File: rtl/exhaustive_sweep_capture.sv
// Exhaustive input sweep generator with per-vector response capture
// and MISR compaction of all responses against a golden signature.
module exhaustive_sweep_capture #(
    parameter int               N_IN   = 2,
    parameter int               N_OUT  = 1,
    parameter int               SETTLE = 0,
    parameter int               GRAY   = 0,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = '0
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic [SIG_W-1:0] golden,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             vec_valid,
    output logic [N_IN-1:0]  vec_pattern,
    output logic [N_OUT-1:0] vec_response,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [N_IN:0] LAST     = {1'b0, {N_IN{1'b1}}};
    localparam logic [7:0]    SETTLE_C = 8'(SETTLE);
    localparam bit            USE_GRAY = (GRAY != 0);

    state_t           state;
    state_t           state_next;
    logic [N_IN:0]    idx;
    logic [N_IN:0]    idx_inc;
    logic [7:0]       cnt;
    logic             take_start;
    logic             capture;
    logic             last;
    logic [N_IN-1:0]  pat_next;
    logic [SIG_W-1:0] resp_ext;
    logic [SIG_W-1:0] sig_step;

    assign take_start = start && (state == S_IDLE || state == S_DONE);
    assign capture    = (state == S_DRIVE) && !hold && (cnt == SETTLE_C);
    assign last       = (idx == LAST);
    assign idx_inc    = idx + 1'b1;

    // Pattern for the next vector, prepared so dut_in moves with idx.
    always_comb begin
        pat_next = idx_inc[N_IN-1:0];
        if (USE_GRAY) begin
            pat_next = idx_inc[N_IN-1:0] ^ (idx_inc[N_IN-1:0] >> 1);
        end
    end

    always_comb begin
        resp_ext = '0;
        resp_ext[N_OUT-1:0] = dut_out;
    end

    assign sig_step = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ resp_ext;

    always_ff @(posedge CK) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (take_start) state_next = S_DRIVE;
            S_DRIVE: if (capture && last) state_next = S_DONE;
            S_DONE:  if (take_start) state_next = S_DRIVE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_DRIVE);
    assign done = (state == S_DONE);

    always_ff @(posedge CK) begin
        if (reset) begin
            idx          <= '0;
            cnt          <= '0;
            signature    <= SEED;
            dut_in       <= '0;
            vec_valid    <= 1'b0;
            vec_pattern  <= '0;
            vec_response <= '0;
            pass         <= 1'b0;
        end else begin
            vec_valid <= 1'b0;
            if (take_start) begin
                idx       <= '0;
                cnt       <= '0;
                signature <= SEED;
                dut_in    <= '0;
                pass      <= 1'b0;
            end else if (state == S_DRIVE && !hold) begin
                if (capture) begin
                    vec_valid    <= 1'b1;
                    vec_pattern  <= dut_in;
                    vec_response <= dut_out;
                    signature    <= sig_step;
                    if (last) begin
                        // Verdict is frozen at DONE entry.
                        pass <= (sig_step == golden);
                    end else begin
                        idx    <= idx_inc;
                        cnt    <= '0;
                        dut_in <= pat_next;
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: table vectors, corner sequences
// and randomized truth tables against a behavioural sweep model.
module tb_exhaustive_sweep_capture;

    logic        CK = 1'b0;
    logic        reset;
    logic        start [2];
    logic        hold  [2];
    logic [15:0] golden [2];
    logic [15:0] lut [2][8];

    always #5 CK = ~CK;

    logic [1:0]  din_a;
    logic        dout_a;
    logic        vv_a;
    logic [1:0]  vp_a;
    logic        vr_a;
    logic        busy_a;
    logic        done_a;
    logic [15:0] sig_a;
    logic        pass_a;

    logic [2:0]  din_b;
    logic [2:0]  dout_b;
    logic        vv_b;
    logic [2:0]  vp_b;
    logic [2:0]  vr_b;
    logic        busy_b;
    logic        done_b;
    logic [15:0] sig_b;
    logic        pass_b;

    assign dout_a = lut[0][{1'b0, din_a}][0];
    assign dout_b = lut[1][din_b][2:0];

    exhaustive_sweep_capture #(
        .N_IN(2), .N_OUT(1), .SETTLE(0), .GRAY(0)
    ) u_a (
        .CK(CK), .reset(reset), .start(start[0]), .hold(hold[0]),
        .golden(golden[0]), .dut_in(din_a), .dut_out(dout_a),
        .vec_valid(vv_a), .vec_pattern(vp_a), .vec_response(vr_a),
        .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a)
    );

    exhaustive_sweep_capture #(
        .N_IN(3), .N_OUT(3), .SETTLE(2), .GRAY(1)
    ) u_b (
        .CK(CK), .reset(reset), .start(start[1]), .hold(hold[1]),
        .golden(golden[1]), .dut_in(din_b), .dut_out(dout_b),
        .vec_valid(vv_b), .vec_pattern(vp_b), .vec_response(vr_b),
        .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b)
    );

    logic        vv [2];
    logic        bz [2];
    logic        dn [2];
    logic        ps [2];
    logic [15:0] din [2];
    logic [15:0] vp [2];
    logic [15:0] vr [2];
    logic [15:0] sig [2];

    always_comb begin
        vv[0]  = vv_a;            vv[1]  = vv_b;
        bz[0]  = busy_a;          bz[1]  = busy_b;
        dn[0]  = done_a;          dn[1]  = done_b;
        ps[0]  = pass_a;          ps[1]  = pass_b;
        din[0] = {14'd0, din_a};  din[1] = {13'd0, din_b};
        vp[0]  = {14'd0, vp_a};   vp[1]  = {13'd0, vp_b};
        vr[0]  = {15'd0, vr_a};   vr[1]  = {13'd0, vr_b};
        sig[0] = sig_a;           sig[1] = sig_b;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nin_of(input int inst);
        return (inst == 1) ? 3 : 2;
    endfunction

    function automatic int pat_of(input int inst, input int i);
        return (inst == 1) ? (i ^ (i >> 1)) : i;
    endfunction

    function automatic int resp_of(input int inst, input int p);
        return int'(lut[inst][p]) & ((inst == 1) ? 7 : 1);
    endfunction

    // Signature a MISR reaches after folding every response in sweep order.
    function automatic int model_sig(input int inst);
        int s = 0;
        for (int i = 0; i < (1 << nin_of(inst)); i++) begin
            s = ((s << 1) & 16'hFFFF) ^ ((s & 16'h8000) != 0 ? 16'h1021 : 0);
            s = s ^ resp_of(inst, pat_of(inst, i));
        end
        return s;
    endfunction

    task automatic sweep(input int inst, input logic [15:0] gold,
                         input int hold_at, input int hold_len,
                         input bit poke);
        int nv    = 1 << nin_of(inst);
        int st    = (inst == 1) ? 2 : 0;
        int t_exp = nv * (st + 1) + hold_len;
        int cyc   = 0;
        int k     = 0;
        int ms    = model_sig(inst);
        bit hd;
        logic [15:0] pd;
        logic [15:0] pg;
        golden[inst] = gold;
        start[inst]  = 1'b1;
        @(posedge CK); #1;
        start[inst]  = 1'b0;
        chk("start_busy", int'(bz[inst]), 1);
        chk("start_done", int'(dn[inst]), 0);
        chk("start_pass", int'(ps[inst]), 0);
        chk("start_din", int'(din[inst]), 0);
        chk("start_sig", int'(sig[inst]), 0);
        while (!dn[inst] && cyc < t_exp + 20) begin
            hd = (hold_len > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
            hold[inst]  = hd;
            start[inst] = poke && (cyc == 2);
            pd = din[inst];
            pg = sig[inst];
            @(posedge CK); #1;
            cyc++;
            if (hd) begin
                chk("hold_din", int'(din[inst]), int'(pd));
                chk("hold_sig", int'(sig[inst]), int'(pg));
                chk("hold_vv", int'(vv[inst]), 0);
            end
            if (vv[inst]) begin
                if (k < nv) begin
                    chk("pattern", int'(vp[inst]), pat_of(inst, k));
                    chk("response", int'(vr[inst]), resp_of(inst, pat_of(inst, k)));
                end
                k++;
            end
        end
        hold[inst]  = 1'b0;
        start[inst] = 1'b0;
        chk("vec_count", k, nv);
        chk("sweep_cycles", cyc, t_exp);
        chk("signature", int'(sig[inst]), ms);
        chk("pass", int'(ps[inst]), (ms == int'(gold)) ? 1 : 0);
        chk("done", int'(dn[inst]), 1);
        chk("busy", int'(bz[inst]), 0);
        chk("din_last", int'(din[inst]), pat_of(inst, nv - 1));
    endtask

    typedef struct {
        logic [3:0]  tt;
        logic [15:0] gold;
        logic [15:0] sig;
        logic        pass;
    } vec_t;

    vec_t tab [4];
    int   s_ref;

    initial begin
        tab[0] = '{4'b1000, 16'h0001, 16'h0001, 1'b1};
        tab[1] = '{4'b0110, 16'h0001, 16'h0006, 1'b0};
        tab[2] = '{4'b1110, 16'h0007, 16'h0007, 1'b1};
        tab[3] = '{4'b0111, 16'h0001, 16'h000E, 1'b0};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; hold[i] = 1'b0; golden[i] = 16'h0;
            for (int j = 0; j < 8; j++) lut[i][j] = 16'h0;
        end
        repeat (3) @(posedge CK);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", int'(bz[i]), 0);
            chk("rst_done", int'(dn[i]), 0);
            chk("rst_pass", int'(ps[i]), 0);
            chk("rst_vv", int'(vv[i]), 0);
            chk("rst_din", int'(din[i]), 0);
            chk("rst_sig", int'(sig[i]), 0);
        end

        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 4; j++) lut[0][j] = {15'd0, tab[t].tt[j]};
            sweep(0, tab[t].gold, 0, 0, 1'b0);
            chk("tab_sig", int'(sig[0]), int'(tab[t].sig));
            chk("tab_pass", int'(ps[0]), int'(tab[t].pass));
        end

        for (int j = 0; j < 8; j++) lut[1][j] = 16'($urandom_range(0, 7));
        sweep(1, 16'h0, 0, 0, 1'b0);
        s_ref = int'(sig[1]);
        sweep(1, 16'(s_ref), 4, 5, 1'b0);
        chk("hold_same_sig", int'(sig[1]), s_ref);
        sweep(1, 16'h1234, 0, 0, 1'b1);

        for (int j = 0; j < 4; j++) lut[0][j] = 16'($urandom_range(0, 1));
        sweep(0, 16'h0, 0, 0, 1'b0);
        s_ref = int'(sig[0]);
        start[0] = 1'b1;
        @(posedge CK); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge CK);
        #1 reset = 1'b1;
        @(posedge CK); #1;
        reset = 1'b0;
        chk("mid_rst_busy", int'(bz[0]), 0);
        chk("mid_rst_done", int'(dn[0]), 0);
        chk("mid_rst_din", int'(din[0]), 0);
        chk("mid_rst_vv", int'(vv[0]), 0);
        chk("mid_rst_vp", int'(vp[0]), 0);
        chk("mid_rst_sig", int'(sig[0]), 0);
        @(posedge CK); #1;
        chk("post_rst_vv", int'(vv[0]), 0);
        chk("post_rst_idle", int'(bz[0]), 0);
        sweep(0, 16'(s_ref), 0, 0, 1'b0);
        chk("rst_same_sig", int'(sig[0]), s_ref);

        for (int r = 0; r < 8; r++) begin
            int inst = r % 2;
            int tot  = (inst == 1) ? 24 : 4;
            logic [15:0] g;
            for (int j = 0; j < 8; j++) lut[inst][j] = 16'($urandom);
            g = ($urandom_range(0, 1) == 1) ? 16'(model_sig(inst)) : 16'($urandom);
            sweep(inst, g, $urandom_range(0, tot - 1), $urandom_range(0, 6),
                  1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/exhaustive_sweep_capture.md
Name: exhaustive_sweep_capture

Overview:
- On-chip counterpart of our per-benchmark exhaustive testbenches, parametrised in input width, output width, settle time and sweep order.
- Drives every 2^N_IN input pattern into a benchmark DUT and captures the DUT response for each pattern.
- Streams each (pattern, response) pair out and compacts all responses into a MISR signature, which is compared against a golden value.
- Sits between the trojan-detection harness and the DUT instance.

Parameters:
- N_IN, 2, DUT input width (1..16).
- N_OUT, 1, DUT output width (1..SIG_W).
- SETTLE, 0, extra cycles each vector is held before its response is sampled (0..255).
- GRAY, 0, sweep order: 0 = binary ascending, 1 = reflected Gray code.
- SIG_W, 16, signature width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SEED, 0, MISR initial value.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled in IDLE or DONE only.
- hold  in  1  freezes the sweep while high (DRIVE only).
- golden  in  SIG_W  expected signature.
- dut_in  out  N_IN  pattern driven to DUT.
- dut_out  in  N_OUT  DUT response.
- vec_valid  out  1  one-cycle pulse per captured vector.
- vec_pattern  out  N_IN  applied pattern of the captured vector.
- vec_response  out  N_OUT  sampled dut_out.
- busy  out  1  high in DRIVE.
- done  out  1  high in DONE.
- signature  out  SIG_W  running/final MISR value.
- pass  out  1  in DONE: signature == golden; otherwise 0.

Behaviour:
- Reset (synchronous, active-high; any state, including mid-sweep):
  - state=IDLE; idx=0; cnt=0; signature=SEED.
  - dut_in, vec_valid, vec_pattern, vec_response, busy, done, pass all 0.
  - Any partial sweep is discarded; no vec_valid is emitted.
- Pattern mapping: dut_in = GRAY ? idx^(idx>>1) : idx; dut_in is registered from idx.
- IDLE:
  - start=1 at an edge -> DRIVE, idx=0, cnt=0, signature=SEED, busy=1.
  - start=0 -> remain in IDLE.
- DRIVE, each edge:
  - hold=1: idx, cnt and signature are unchanged; vec_valid=0.
  - hold=0 and cnt<SETTLE: cnt++.
  - hold=0 and cnt==SETTLE (capture edge):
    - vec_response=dut_out; vec_pattern=current dut_in; vec_valid=1 for that one cycle.
    - signature = {signature[SIG_W-2:0],0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended dut_out.
    - If idx == 2^N_IN-1 -> DONE. Otherwise idx++ and cnt=0.
  - Each vector is held exactly SETTLE+1 unheld cycles.
  - A full sweep without hold takes 2^N_IN*(SETTLE+1) cycles from the start edge to the DONE entry.
  - start is ignored in DRIVE.
- DONE:
  - busy=0, done=1, pass registered on entry; signature frozen; dut_in holds the last pattern.
  - start=1 restarts exactly as from IDLE; done and pass drop on that edge.
- Simultaneous events:
  - reset has priority over start and hold.
  - hold and start together in IDLE/DONE: start is taken.
- idx is N_IN+1 bits wide, so the last-vector compare has no wrap ambiguity.

Test Plan:
- N_IN=2, SETTLE=0, GRAY=0, DUT = N[0]&N[1] -> vec_valid pulses 4 consecutive cycles, patterns 00,01,10,11, responses 0,0,0,1; signature=16'h0001; golden=16'h0001 gives pass=1; DONE 4 cycles after start.
- Same setup with DUT = XOR -> responses 0,1,1,0, signature=16'h0006; golden=16'h0001 gives pass=0.
- N_IN=3, GRAY=1, SETTLE=2 -> vec_pattern order 000,001,011,010,110,111,101,100; each pattern held 3 cycles; DONE 24 cycles after start.
- hold asserted for 5 cycles mid-vector -> dut_in, signature and vec_valid frozen; total sweep lengthened by exactly 5 cycles; final signature matches the no-hold run.
- reset pulsed while idx=2 -> next cycle all outputs 0, signature=SEED; subsequent start runs a clean full sweep with the same signature as before.
- start pulsed during DRIVE -> ignored; start pulsed in DONE -> new sweep begins, done and pass drop the same edge.
